prime_mask_scan: RTL and testbench

Sequencer that walks a candidate bitmap (e.g. one sieve word) and emits the index of every set bit, highest index first, one per accepted handshake. Internally it instantiates `prio_enc` to find the current MSB and clears each bit after it is consumed. It sits between the sieve bitmap store and the downstream prime consumer, turning a packed mask into a stream of bit positions.

---
 rtl/prime_mask_scan.sv | 133 +++++++++++++
 tb/tb_prime_mask_scan.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/prime_mask_scan.sv
// prime_mask_scan: walks a candidate bitmap (one sieve word) and streams out
// the index of every set bit, highest index first, one per accepted handshake.
//
// Ports:
//   clk    in   sole clock, rising-edge
//   rst    in   asynchronous active-high reset
//   go     in   start request, honoured only while ready=1
//   x      in   WIDTH-bit bitmap, captured on an accepted go
//   abort  in   cancel an active scan (ignored outside SCAN)
//   ready  out  idle, can accept go
//   valid  out  idx holds a valid bit position
//   idx    out  8-bit current bit index, MSB-first
//   ack    in   consumer accepts idx (transfer on valid & ack)
//   done   out  one-cycle pulse after the final index was accepted
//   count  out  indices transferred in the current/last scan
//
// Also contains prio_enc, the MSB finder used to pick the next index.

// prio_enc: index of the highest set bit of 'in', or 0 when 'in' is zero.
module prio_enc #(
  parameter int WIDTH_LOG = 4
) (
  input  logic [(1<<WIDTH_LOG)-1:0] in,
  output logic [7:0]                out
);

  // Scan upward so the last (highest) set bit seen wins.
  always_comb begin
    out = '0;
    for (int i = 0; i < (1 << WIDTH_LOG); i++) begin
      if (in[i]) out = 8'(i);
    end
  end

endmodule

module prime_mask_scan #(
  parameter int WIDTH_LOG = 4,
  parameter int WIDTH     = 1 << WIDTH_LOG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [WIDTH-1:0]     x,
  input  logic                 abort,
  output logic                 ready,
  output logic                 valid,
  output logic [7:0]           idx,
  input  logic                 ack,
  output logic                 done,
  output logic [WIDTH_LOG:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mask;
  logic [WIDTH-1:0]     cleared;
  logic [7:0]           msb_x;
  logic [7:0]           msb_cleared;

  // Mask with the currently presented bit removed; only meaningful in SCAN,
  // where idx always names a set bit of mask.
  assign cleared = mask & ~({{(WIDTH-1){1'b0}}, 1'b1} << idx[WIDTH_LOG-1:0]);

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_start (
    .in  (x),
    .out (msb_x)
  );

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_next (
    .in  (cleared),
    .out (msb_cleared)
  );

  assign ready = (state == IDLE);
  assign valid = (state == SCAN);

  // Sequencer: IDLE captures the bitmap, SCAN hands out one index per
  // accepted transfer, DONE raises the completion pulse for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
      idx   <= '0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            mask  <= x;
            count <= '0;
            idx   <= msb_x;
            if (x != '0) begin
              state <= SCAN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          // abort wins over a simultaneous ack: nothing is consumed.
          if (abort) begin
            state <= IDLE;
            mask  <= '0;
          end else if (ack) begin
            mask  <= cleared;
            count <= count + (WIDTH_LOG+1)'(1);
            idx   <= msb_cleared;
            if (cleared == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_mask_scan.sv
// Testbench for prime_mask_scan: table-driven vectors on a 16-bit instance
// plus hand-written sequences for async reset and an 8-bit full-mask scan.
module tb_prime_mask_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        go = 1'b0;
  logic [15:0] x = '0;
  logic        abort = 1'b0;
  logic        ack = 1'b0;
  logic        ready, valid, done;
  logic [7:0]  idx;
  logic [4:0]  count;

  logic        go8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        abort8 = 1'b0;
  logic        ack8 = 1'b0;
  logic        ready8, valid8, done8;
  logic [7:0]  idx8;
  logic [3:0]  count8;

  int passCount = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  prime_mask_scan #(.WIDTH_LOG(4)) dut16 (
    .clk(clk), .rst(rst), .go(go), .x(x), .abort(abort),
    .ready(ready), .valid(valid), .idx(idx), .ack(ack),
    .done(done), .count(count)
  );

  prime_mask_scan #(.WIDTH_LOG(3)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .x(x8), .abort(abort8),
    .ready(ready8), .valid(valid8), .idx(idx8), .ack(ack8),
    .done(done8), .count(count8)
  );

  typedef struct {
    string       name;
    logic        go;
    logic [15:0] x;
    logic        ack;
    logic        abort;
    logic        e_ready;
    logic        e_valid;
    logic        e_done;
    logic        idx_care;
    logic [7:0]  e_idx;
    logic [4:0]  e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic g, logic [15:0] xv, logic a,
                              logic ab, logic r, logic v, logic d,
                              logic ic, logic [7:0] i, logic [4:0] c);
    vec_t t;
    t.name = n; t.go = g; t.x = xv; t.ack = a; t.abort = ab;
    t.e_ready = r; t.e_valid = v; t.e_done = d;
    t.idx_care = ic; t.e_idx = i; t.e_count = c;
    return t;
  endfunction

  // Single comparison: counts it and reports any mismatch.
  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(logic g, logic [15:0] xv, logic a, logic ab);
    go = g; x = xv; ack = a; abort = ab;
  endtask

  task automatic checkOutput(vec_t t);
    check({t.name, ".ready"}, 32'(ready), 32'(t.e_ready));
    check({t.name, ".valid"}, 32'(valid), 32'(t.e_valid));
    check({t.name, ".done"},  32'(done),  32'(t.e_done));
    check({t.name, ".count"}, 32'(count), 32'(t.e_count));
    if (t.idx_care) check({t.name, ".idx"}, 32'(idx), 32'(t.e_idx));
  endtask

  initial begin
    // Columns: name, go, x, ack, abort | ready, valid, done, idx_care, idx, count
    vecs.push_back(mk("h8421_go",  1, 16'h8421, 1, 0, 0, 1, 0, 1, 15, 0));
    vecs.push_back(mk("h8421_a1",  0, 16'h0000, 1, 0, 0, 1, 0, 1, 10, 1));
    vecs.push_back(mk("h8421_a2",  0, 16'h0000, 1, 0, 0, 1, 0, 1,  5, 2));
    vecs.push_back(mk("h8421_a3",  0, 16'h0000, 1, 0, 0, 1, 0, 1,  0, 3));
    vecs.push_back(mk("h8421_dn",  0, 16'h0000, 1, 0, 0, 0, 1, 0,  0, 4));
    vecs.push_back(mk("h8421_idl", 0, 16'h0000, 0, 0, 1, 0, 0, 0,  0, 4));
    vecs.push_back(mk("idle_hold", 0, 16'h1234, 1, 0, 1, 0, 0, 0,  0, 4));
    vecs.push_back(mk("zero_go",   1, 16'h0000, 1, 0, 0, 0, 1, 1,  0, 0));
    vecs.push_back(mk("zero_dn",   0, 16'h0000, 0, 1, 1, 0, 0, 0,  0, 0));
    vecs.push_back(mk("h3_go",     1, 16'h0003, 0, 0, 0, 1, 0, 1,  1, 0));
    vecs.push_back(mk("h3_bp0",    0, 16'h0000, 0, 0, 0, 1, 0, 1,  1, 0));
    vecs.push_back(mk("h3_bp1",    0, 16'h0000, 0, 0, 0, 1, 0, 1,  1, 0));
    vecs.push_back(mk("h3_a1",     0, 16'h0000, 1, 0, 0, 1, 0, 1,  0, 1));
    vecs.push_back(mk("h3_bp2",    0, 16'h0000, 0, 0, 0, 1, 0, 1,  0, 1));
    vecs.push_back(mk("h3_dn",     0, 16'h0000, 1, 0, 0, 0, 1, 0,  0, 2));
    vecs.push_back(mk("h3_idl",    0, 16'h0000, 0, 0, 1, 0, 0, 0,  0, 2));
    vecs.push_back(mk("ff_go",     1, 16'hFFFF, 1, 0, 0, 1, 0, 1, 15, 0));
    vecs.push_back(mk("ff_a1",     0, 16'h0000, 1, 0, 0, 1, 0, 1, 14, 1));
    vecs.push_back(mk("ff_a2",     0, 16'h0000, 1, 0, 0, 1, 0, 1, 13, 2));
    vecs.push_back(mk("ff_abort",  0, 16'h0000, 1, 1, 1, 0, 0, 0,  0, 2));
    vecs.push_back(mk("ff_nodone", 0, 16'h0000, 0, 0, 1, 0, 0, 0,  0, 2));
    vecs.push_back(mk("mid_go",    1, 16'h0500, 0, 0, 0, 1, 0, 1, 10, 0));
    vecs.push_back(mk("mid_ign1",  1, 16'hFFFF, 1, 0, 0, 1, 0, 1,  8, 1));
    vecs.push_back(mk("mid_ign2",  1, 16'hFFFF, 1, 0, 0, 0, 1, 0,  0, 2));
    vecs.push_back(mk("mid_idl",   0, 16'h0000, 0, 0, 1, 0, 0, 0,  0, 2));

    // Reset asserted between edges must take effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst0.ready", 32'(ready), 1);
    check("rst0.valid", 32'(valid), 0);
    check("rst0.done",  32'(done),  0);
    check("rst0.idx",   32'(idx),   0);
    check("rst0.count", 32'(count), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].go, vecs[i].x, vecs[i].ack, vecs[i].abort);
      @(posedge clk);
      @(negedge clk);
      checkOutput(vecs[i]);
    end

    // Async reset in the middle of a scan.
    applyStimulus(1, 16'h8421, 1, 0);
    @(posedge clk); @(negedge clk);
    applyStimulus(0, 16'h0000, 1, 0);
    @(posedge clk); @(negedge clk);
    check("pre_rst.idx",   32'(idx),   10);
    check("pre_rst.count", 32'(count), 1);
    #2 rst = 1'b1;
    #1;
    check("rst1.ready", 32'(ready), 1);
    check("rst1.valid", 32'(valid), 0);
    check("rst1.done",  32'(done),  0);
    check("rst1.idx",   32'(idx),   0);
    check("rst1.count", 32'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 16'h0000, 0, 0);

    // 8-bit instance, full mask: every index 7..0 with no count overflow.
    go8 = 1'b1; x8 = 8'hFF; ack8 = 1'b1;
    @(posedge clk); @(negedge clk);
    go8 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("w8.idx%0d", i),   32'(idx8),   32'(i));
      check($sformatf("w8.valid%0d", i), 32'(valid8), 1);
      check($sformatf("w8.cnt%0d", i),   32'(count8), 32'(7 - i));
      @(posedge clk); @(negedge clk);
    end
    check("w8.done",  32'(done8),  1);
    check("w8.count", 32'(count8), 8);
    ack8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("w8.ready", 32'(ready8), 1);
    check("w8.done_low", 32'(done8), 0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
